// File: rtl/axi_sram_pkg.sv
// rtl/axi_sram_pkg.sv - shared encodings and widths for the AXI SRAM read/write bridges
package axi_sram_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_ID_W   = 4;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  // Requests the bridge answers with SLVERR beats and no SRAM traffic.
  function automatic logic bad_request(input logic [1:0] burst, input logic [2:0] size);
    return (burst == BURST_WRAP) || (burst == 2'd3) || (size > 3'd3);
  endfunction

endpackage

// File: rtl/axi_sram_rd_skid.sv
// rtl/axi_sram_rd_skid.sv - 2-entry beat FIFO holding R beats while rready is low
module axi_sram_rd_skid #(
  parameter int W = 67
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wptr;
  logic         rptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wptr] <= push_data;
        wptr      <= ~wptr;
      end
      if (do_pop) rptr <= ~rptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head  = mem[rptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/axi_sram_rd_bridge.sv
// rtl/axi_sram_rd_bridge.sv - AXI4 AR/R responder over a synchronous SRAM read port
// Optional per-beat address range check: AXI_SRAM_RD_RANGE_CHECK_EN.
module axi_sram_rd_bridge
  import axi_sram_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ID_W      = DEF_ID_W,
  parameter int RAM_BYTES = 65536
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  output logic              ram_ren,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int BEAT_W = DATA_W + 3;

`ifdef AXI_SRAM_RD_RANGE_CHECK_EN
  localparam logic RANGE_CHECK = 1'b1;
`else
  localparam logic RANGE_CHECK = 1'b0;
`endif
  localparam logic [ADDR_W:0] RAM_LIMIT = (ADDR_W+1)'(RAM_BYTES);

  rd_state_e         state, state_nx;
  logic              live_q;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [7:0]        issue_cnt;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic              bad_q;
  logic              pend_valid, pend_err, pend_last;
  logic              ar_fire, r_fire, beat_go, beat_err, credit_ok, last_issue;
  logic [1:0]        occ;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [BEAT_W-1:0] pend_beat, head_beat, out_beat;

  assign ar_fire    = arvalid && arready;
  assign r_fire     = rvalid && rready;
  assign last_issue = (issue_cnt == len_q);
  assign beat_err   = bad_q || (RANGE_CHECK && ({1'b0, addr_q} >= RAM_LIMIT));
  // A pending beat lands in the FIFO if not taken, so it counts against the two slots.
  assign credit_ok  = !fifo_full && (({1'b0, occ} + {2'b0, pend_valid}) < 3'd2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (ar_fire) state_nx = ST_ISSUE;
      ST_ISSUE: if (beat_go && last_issue) state_nx = ST_DRAIN;
      ST_DRAIN: if (r_fire && rlast) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    arready = 1'b0;
    beat_go = 1'b0;
    case (state)
      ST_IDLE:  arready = live_q;
      ST_ISSUE: beat_go = credit_ok;
      default:  ;
    endcase
  end

  assign ram_ren   = beat_go && !beat_err;
  assign ram_raddr = addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live_q     <= 1'b0;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= 8'd0;
      size_q     <= 3'd0;
      burst_q    <= BURST_FIXED;
      bad_q      <= 1'b0;
      issue_cnt  <= 8'd0;
      pend_valid <= 1'b0;
      pend_err   <= 1'b0;
      pend_last  <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (ar_fire) begin
        id_q      <= arid;
        addr_q    <= araddr;
        len_q     <= arlen;
        size_q    <= arsize;
        burst_q   <= arburst;
        bad_q     <= bad_request(arburst, arsize);
        issue_cnt <= 8'd0;
      end else if (beat_go) begin
        issue_cnt <= issue_cnt + 8'd1;
        if (burst_q == BURST_INCR) addr_q <= addr_q + (ADDR_W'(1) << size_q);
      end
      // Beat metadata travels alongside the SRAM read so it lines up with ram_rdata.
      pend_valid <= beat_go;
      pend_err   <= beat_err;
      pend_last  <= beat_go && last_issue;
    end
  end

  assign pend_beat = {pend_last,
                      pend_err ? RESP_SLVERR : RESP_OKAY,
                      pend_err ? {DATA_W{1'b0}} : ram_rdata};

  // SRAM data is only valid for one cycle: it bypasses to R when the FIFO is empty and
  // rready is high, otherwise it is captured so the R outputs stay stable.
  assign fifo_push = pend_valid && !(fifo_empty && rready);
  assign fifo_pop  = r_fire && !fifo_empty;

  axi_sram_rd_skid #(.W(BEAT_W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (pend_beat),
    .pop       (fifo_pop),
    .head      (head_beat),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (occ)
  );

  always_comb begin
    out_beat = '0;
    if (!fifo_empty)     out_beat = head_beat;
    else if (pend_valid) out_beat = pend_beat;
  end

  assign rvalid                = !fifo_empty || pend_valid;
  assign {rlast, rresp, rdata} = out_beat;
  assign rid                   = id_q;

endmodule

// File: doc/axi_sram_rd_bridge.md
Name: axi_sram_rd_bridge

Overview:
- AXI4 read-channel responder (AR/R) in front of a synchronous single-port-read SRAM.
- It is the read-side counterpart of the existing AXI write path driven by fake_cpu in top.
- It accepts one burst at a time, issues one SRAM read per beat, and returns beats on R with full rready backpressure support.
- It sits between fake_cpu's AR/R channels and the SRAM read port (ram_ren/ram_raddr/ram_rdata) inside top.

Parameters:
- ADDR_W, 32, address width of araddr/ram_raddr.
- DATA_W, 64, data width of rdata/ram_rdata.
- ID_W, 4, width of arid/rid.
- RAM_BYTES, 65536, SRAM size in bytes; used only by the optional range check.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- arid  in  ID_W  read transaction ID.
- araddr  in  ADDR_W  start byte address.
- arlen  in  8  beats minus one.
- arsize  in  3  log2 of bytes per beat; legal values 0..3.
- arburst  in  2  burst type: 0 FIXED, 1 INCR, 2 WRAP.
- arvalid  in  1  AR request valid.
- arready  out  1  AR accept.
- rid  out  ID_W  echo of the captured arid.
- rdata  out  DATA_W  read data.
- rresp  out  2  0 OKAY, 2 SLVERR.
- rlast  out  1  final beat of the burst.
- rvalid  out  1  R beat valid.
- rready  in  1  R beat accept.
- ram_ren  out  1  SRAM read enable.
- ram_raddr  out  ADDR_W  SRAM byte address.
- ram_rdata  in  DATA_W  SRAM data, valid the cycle after ram_ren.

Behaviour:
- Reset values: arready=0, rvalid=0, rlast=0, rid=0, rresp=0, rdata=0, ram_ren=0, ram_raddr=0. The FSM resets to IDLE and the skid buffer resets to empty. arready goes to 1 on the first clock after reset deasserts.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: arready=1. An AR handshake (arvalid&arready) captures id, addr, len, size and burst, clears the beat counter, drops arready, and moves to ISSUE.
  - ISSUE: ram_ren=1 when (buffer occupancy + in-flight reads) < 2. ram_raddr = current address. Each issued read increments the issue counter and advances the address. After the arlen+1-th issue, move to DRAIN.
  - DRAIN: wait until the buffer is empty and the rlast beat has been accepted, then go to IDLE with arready=1 on the next cycle.
- Address update: INCR adds 1<<arsize to the address. FIXED holds the address constant. The address wraps modulo 2^ADDR_W with no error.
- WRAP bursts or arsize>3: no SRAM reads are issued. The block returns arlen+1 beats with rresp=SLVERR and rdata=0.
- Latency: AR handshake on cycle T -> ram_ren on T+1 -> rvalid on T+2 (with rready=1).
- Throughput: one beat per cycle while rready stays high.
- Skid buffer: 2 entries holding {data, resp, last}. A beat transfers when rvalid&rready. rvalid, rdata, rresp, rlast and rid hold stable while rvalid=1 and rready=0.
- rlast=1 only on beat arlen. It is set for single beats (arlen=0).
- Simultaneous events:
  - Buffer push and pop in the same cycle leave occupancy unchanged.
  - The AR handshake is never accepted outside IDLE, so only one burst is ever outstanding.
- Reset mid-burst: async clear of all state. rvalid drops immediately, in-flight SRAM data is discarded, and no partial burst resumes.

Optional Feature:
- Macro: AXI_SRAM_RD_RANGE_CHECK_EN.
- Defined: any beat whose address is >= RAM_BYTES returns rresp=SLVERR and rdata=0, with no ram_ren for that beat. Beat timing and rlast are unchanged, and in-range beats of the same burst return OKAY.
- Undefined: no range check. ram_raddr is driven unmodified and every beat is OKAY, except the WRAP/arsize cases above.

Decomposition:
- Shared package axi_sram_pkg holds:
  - burst encodings BURST_FIXED/INCR/WRAP;
  - response codes RESP_OKAY/SLVERR;
  - the FSM state enum;
  - default widths.
- The write bridge imports the same package.
- One sub-module: axi_sram_rd_skid, a 2-entry FIFO with full/empty and occupancy outputs. The parent owns the FSM, the address generator and the issue credit logic.

Test Plan:
- Single beat: SRAM[0x4]=64'habcdaaaa12345678; AR arid=3, araddr=0x4, arlen=0, arsize=2, arburst=INCR; rready=1. Required: ram_raddr=0x4 at T+1; rvalid at T+2 with that rdata, rid=3, rlast=1, rresp=0; arready back to 1 afterwards.
- INCR burst: araddr=0x100, arlen=3, arsize=3. Required: ram_raddr=0x100, 0x108, 0x110, 0x118 on consecutive cycles; 4 back-to-back beats; rlast only on the 4th.
- Backpressure: same burst with rready pattern 1,0,0,1,0,1,1. Required: exactly 4 beats in order, none lost or duplicated, R outputs stable while stalled, and ram_ren throttled so the buffer never overflows.
- FIXED and WRAP:
  - FIXED: araddr=0x20, arlen=2 -> ram_raddr=0x20 three times.
  - WRAP: arlen=1 -> no ram_ren; 2 beats with rresp=SLVERR and rdata=0.
- Reset mid-burst: assert reset after the 2nd beat of an arlen=7 burst. Required: rvalid=0 and arready=0 immediately. After release, a new burst at 0x4 returns correct data with no stale beats.
- With AXI_SRAM_RD_RANGE_CHECK_EN defined and RAM_BYTES=0x10000: araddr=0xFFF8, arlen=1, arsize=3. Required: beat 0 OKAY, beat 1 SLVERR with rdata=0, and only one ram_ren.
